conv_frame_packer: RTL and testbench
====================================

Name: conv_frame_packer

Overview:
- Writer side of the conv layer's packed `data` bus.
- Accepts input pixels as a valid/ready stream, one per clock, and assembles them into the flat `IBW*length` frame vector that the conv layer consumes.
- The completed frame is published atomically, so the conv layer's data-change-triggered evaluation fires exactly once per frame.
- Double-buffered: the next frame fills while the previous one is held.

Parameters:
- IBW, 8, pixel width in bits (signed two's complement, passed through unmodified).
- height, 28, rows per channel.
- width, 28, columns per row.
- channels, 1, channel planes per frame.
- length, height*width, elements per channel plane; frame vector is IBW*length*channels bits.
- CNTW, 16, width of frame counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_pix  in  IBW  pixel value.
- s_valid  in  1  pixel beat valid.
- s_ready  out  1  packer can accept beat; transfer occurs when s_valid & s_ready at rising clk.
- s_sof  in  1  beat is first pixel of frame (ch 0, row 0, col 0).
- s_eol  in  1  beat is last pixel of a row.
- frame_data  out  IBW*length*channels  packed frame; element e at bits [e*IBW +: IBW], e = (ch*height+row)*width+col.
- frame_valid  out  1  frame_data holds a complete unacknowledged frame.
- frame_ack  in  1  consumer done with frame_data.
- err_sync  out  1  one-cycle pulse on framing error.
- frame_cnt  out  CNTW  number of frames published since reset, wraps modulo 2^CNTW.

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state=IDLE; internal fill buffer and frame_data cleared to 0.
  - frame_valid=0, err_sync=0, frame_cnt=0; col/row/ch counters=0.
  - s_ready=0 while rst is high.
  - Reset mid-fill or mid-hold discards everything.
- States: IDLE (await sof), FILL (collecting).
  - Publish status is tracked separately by frame_valid.
- s_ready=1 in both states except the stall case below.
- IDLE:
  - Accepted beat with s_sof=1: write pixel to element 0, set col=1 (or advance row/ch per wrap rules), go to FILL.
  - Accepted beat with s_sof=0: dropped, err_sync pulses the next cycle.
- FILL, per accepted beat:
  - Write s_pix to element index; advance col.
  - When col wraps at width-1, advance row; when row wraps at height-1, advance ch.
  - s_eol must be 1 exactly when col==width-1. Any mismatch: beat dropped, fill discarded, err_sync pulses, return to IDLE.
  - s_sof=1 mid-frame: err_sync pulses, the beat is treated as a new frame start (written to element 0, counters restart), stay in FILL.
  - eol/sof checks apply with priority: sof first, then eol.
- Completion, on the accepted beat for element length*channels-1:
  - Next cycle, frame_data = full buffer including that pixel.
  - frame_valid=1, frame_cnt+1, state=IDLE.
  - Latency: last pixel to frame_valid is 1 cycle.
- Hold:
  - frame_data is stable while frame_valid=1.
  - frame_ack while frame_valid=1 clears frame_valid next cycle.
  - frame_ack while frame_valid=0 is ignored.
  - frame_data keeps its value after ack; it changes only on publish.
- Stall: s_ready=0 when state==FILL, the next beat is the last element, frame_valid=1 and frame_ack=0 (combinational from these).
- Simultaneous completion and frame_ack: the publish wins. frame_data is replaced, frame_valid stays 1, frame_cnt increments.
- Single-element frame (length*channels==1): the sof beat completes the frame directly from IDLE. Stall rule applies to IDLE in this case.
- Fill buffer writes never disturb frame_data.

Test Plan:
- Params height=2, width=3, channels=1, IBW=8. Stream 01..06 with sof on beat 0, eol on beats 2 and 5, no gaps:
  - frame_valid rises 1 cycle after beat 5.
  - frame_data=48'h060504030201, frame_cnt=1.
- Same frame with s_valid toggling 1010… and frame_data monitored during fill:
  - frame_data stays 0 until publish, then equals 48'h060504030201 exactly once.
- Hold frame A unacked, stream frame B (11..16):
  - s_ready drops at B's 6th beat until frame_ack.
  - Ack in the same cycle as the last beat: frame_data=48'h161514131211, frame_valid stays 1, frame_cnt=2.
- eol asserted on beat 1 (col 1):
  - err_sync pulses once, frame_valid stays 0.
  - A following clean frame publishes correctly.
- Beat without sof in IDLE:
  - Dropped, err_sync pulse.
  - sof reasserted on beat 3 of a fill: err_sync pulse, frame restarts, and the published frame contains only the post-restart pixels.
- Assert rst for 1 cycle mid-fill and while frame_valid=1:
  - Next cycle frame_valid=0, frame_data=0, frame_cnt=0, s_ready=1 after rst falls.

Source files
------------

// File: rtl/conv_frame_packer_if.sv
// rtl/conv_frame_packer_if.sv - pixel stream in, packed frame out, for the conv frame packer
interface conv_frame_packer_if #(
  parameter int IBW  = 8,
  parameter int FW   = IBW * 784,
  parameter int CNTW = 16
);
  logic [IBW-1:0]  s_pix;
  logic            s_valid;
  logic            s_ready;
  logic            s_sof;
  logic            s_eol;
  logic [FW-1:0]   frame_data;
  logic            frame_valid;
  logic            frame_ack;
  logic            err_sync;
  logic [CNTW-1:0] frame_cnt;

  modport master (
    output s_pix, s_valid, s_sof, s_eol, frame_ack,
    input  s_ready, frame_data, frame_valid, err_sync, frame_cnt
  );

  modport slave (
    input  s_pix, s_valid, s_sof, s_eol, frame_ack,
    output s_ready, frame_data, frame_valid, err_sync, frame_cnt
  );
endinterface

// File: rtl/conv_frame_packer.sv
// rtl/conv_frame_packer.sv - assembles a pixel stream into a double-buffered, atomically published frame
module conv_frame_packer #(
  parameter int IBW      = 8,
  parameter int height   = 28,
  parameter int width    = 28,
  parameter int channels = 1,
  parameter int length   = height * width,
  parameter int CNTW     = 16
) (
  input  logic clk,
  input  logic rst,
  conv_frame_packer_if.slave bus
);
  localparam int NELEM = length * channels;
  localparam int FW    = IBW * NELEM;
  localparam int IW    = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam int CW    = (width > 1) ? $clog2(width) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NELEM - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(width - 1);
  localparam bit ONE_ELEM = (NELEM == 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   col;
  logic [FW-1:0]   fill;
  logic [FW-1:0]   next_fill;
  logic [FW-1:0]   frame_data_q;
  logic            frame_valid_q;
  logic            err_q;
  logic [CNTW-1:0] cnt_q;
  logic [IW-1:0]   wr_idx;
  logic [CW-1:0]   wr_col;
  logic            stall, beat, at_last, col_end;

  // Element and row/channel position are implied by the linear index; only the
  // column is kept separately for the end-of-line check.
  assign wr_idx  = bus.s_sof ? '0 : idx;
  assign wr_col  = bus.s_sof ? '0 : col;
  assign at_last = (wr_idx == LAST_IDX);
  assign col_end = (wr_col == LAST_COL);

  // Hold off the frame-completing beat while the published frame is still owned.
  assign stall = (ONE_ELEM || (state == FILL && idx == LAST_IDX))
                 && frame_valid_q && !bus.frame_ack;
  assign bus.s_ready = !rst && !stall;
  assign beat        = bus.s_valid && bus.s_ready;

  always_comb begin
    next_fill = fill;
    next_fill[int'(wr_idx) * IBW +: IBW] = bus.s_pix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      col           <= '0;
      fill          <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
    end else begin
      err_q <= 1'b0;
      if (bus.frame_ack && frame_valid_q)
        frame_valid_q <= 1'b0;
      if (beat) begin
        if (!bus.s_sof && state == IDLE) begin
          err_q <= 1'b1;
        end else if (!bus.s_sof && (bus.s_eol != col_end)) begin
          err_q <= 1'b1;
          state <= IDLE;
        end else begin
          if (bus.s_sof && state == FILL)
            err_q <= 1'b1;
          fill <= next_fill;
          if (at_last) begin
            // Publish overrides a same-cycle ack.
            frame_data_q  <= next_fill;
            frame_valid_q <= 1'b1;
            cnt_q         <= cnt_q + 1'b1;
            state         <= IDLE;
            idx           <= '0;
            col           <= '0;
          end else begin
            state <= FILL;
            idx   <= wr_idx + 1'b1;
            col   <= col_end ? '0 : wr_col + 1'b1;
          end
        end
      end
    end
  end

  assign bus.frame_data  = frame_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.err_sync    = err_q;
  assign bus.frame_cnt   = cnt_q;
endmodule

// File: tb/tb_conv_frame_packer.sv
// tb/tb_conv_frame_packer.sv - bench for conv_frame_packer with a queue-based frame model
module tb_conv_frame_packer;
  localparam int IBW  = 8;
  localparam int H    = 2;
  localparam int W    = 3;
  localparam int C    = 1;
  localparam int N    = H * W * C;
  localparam int FW   = IBW * N;
  localparam int CNTW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_frame_packer_if #(.IBW(IBW), .FW(FW), .CNTW(CNTW)) bus ();

  conv_frame_packer #(
    .IBW(IBW), .height(H), .width(W), .channels(C), .CNTW(CNTW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame model: the current fill is just the list of pixels collected so far.
  bit              m_fill  = 0;
  logic [IBW-1:0]  m_buf[$];
  logic [FW-1:0]   m_data  = '0;
  bit              m_valid = 0;
  bit              m_err   = 0;
  int unsigned     m_cnt   = 0;

  function automatic bit m_ready();
    if (rst) return 1'b0;
    if (m_fill && m_buf.size() == N - 1 && m_valid && !bus.frame_ack) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit rdy;
    rdy = m_ready();
    if (rst) begin
      m_fill = 0; m_buf.delete(); m_data = '0; m_valid = 0; m_err = 0; m_cnt = 0;
    end else begin
      m_err = 0;
      if (bus.frame_ack && m_valid) m_valid = 0;
      if (bus.s_valid && rdy) begin
        if (bus.s_sof) begin
          m_err = m_fill;
          m_fill = 1;
          m_buf.delete();
          m_buf.push_back(bus.s_pix);
        end else if (!m_fill) begin
          m_err = 1;
        end else if (bus.s_eol != ((m_buf.size() % W) == W - 1)) begin
          m_err = 1;
          m_fill = 0;
        end else begin
          m_buf.push_back(bus.s_pix);
        end
        if (m_fill && m_buf.size() == N) begin
          for (int e = 0; e < N; e++) m_data[e*IBW +: IBW] = m_buf[e];
          m_valid = 1;
          m_cnt++;
          m_fill = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    chk("frame_data",  bus.frame_data,  m_data);
    chk("frame_valid", bus.frame_valid, m_valid);
    chk("err_sync",    bus.err_sync,    m_err);
    chk("frame_cnt",   bus.frame_cnt,   m_cnt & 32'hFFFF);
    chk("s_ready",     bus.s_ready,     m_ready());
  end

  task automatic beat(input logic [7:0] pix, input bit sof, input bit eol, input bit ack = 0);
    @(negedge clk);
    bus.s_valid = 1; bus.s_pix = pix; bus.s_sof = sof; bus.s_eol = eol; bus.frame_ack = ack;
  endtask

  task automatic idle(input int n = 1, input bit ack = 0);
    repeat (n) begin
      @(negedge clk);
      bus.s_valid = 0; bus.s_sof = 0; bus.s_eol = 0; bus.frame_ack = ack;
    end
  endtask

  task automatic send_frame(input logic [7:0] base, input bit gaps = 0);
    for (int i = 0; i < N; i++) begin
      beat(base + 8'(i), i == 0, (i % W) == W - 1);
      if (gaps) idle(1);
    end
  endtask

  task automatic ack_frame();
    idle(1, 1);
    idle(1);
  endtask

  initial begin
    bus.s_valid = 0; bus.s_pix = '0; bus.s_sof = 0; bus.s_eol = 0; bus.frame_ack = 0;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_data_lit",  bus.frame_data, 48'h0);
    chk("rst_ready_lit", bus.s_ready, 1'b0);
    @(negedge clk);
    rst = 0;

    // back-to-back frame
    send_frame(8'h01);
    idle(1); #3;
    chk("f1_data_lit",  bus.frame_data, 48'h060504030201);
    chk("f1_model_pin", m_data,         48'h060504030201);
    chk("f1_valid_lit", bus.frame_valid, 1'b1);
    chk("f1_cnt_lit",   bus.frame_cnt,   16'd1);
    ack_frame();

    // gapped fill
    send_frame(8'h01, 1);
    #3;
    chk("f2_data_lit", bus.frame_data, 48'h060504030201);
    chk("f2_cnt_lit",  bus.frame_cnt,  16'd2);
    ack_frame();

    // frame A held unacked, frame B stalls on its last beat, then ack coincides with it
    send_frame(8'h01);
    idle(1);
    for (int i = 0; i < N - 1; i++) beat(8'h11 + 8'(i), i == 0, (i % W) == W - 1);
    repeat (3) begin
      beat(8'h16, 0, 1, 0); #3;
      chk("stall_ready_lit", bus.s_ready, 1'b0);
    end
    beat(8'h16, 0, 1, 1);
    idle(1); #3;
    chk("fb_data_lit",  bus.frame_data,  48'h161514131211);
    chk("fb_valid_lit", bus.frame_valid, 1'b1);
    chk("fb_cnt_lit",   bus.frame_cnt,   16'd4);
    ack_frame();

    // eol on the wrong column
    beat(8'h21, 1, 0);
    beat(8'h22, 0, 1);
    idle(1); #3;
    chk("eol_err_lit",   bus.err_sync,    1'b1);
    chk("eol_valid_lit", bus.frame_valid, 1'b0);
    idle(1); #3;
    chk("eol_err_once_lit", bus.err_sync, 1'b0);
    send_frame(8'h31);
    idle(1); #3;
    chk("f5_data_lit", bus.frame_data, 48'h363534333231);
    ack_frame();

    // beat without sof in IDLE, then sof restart mid-frame
    beat(8'h41, 0, 0);
    idle(1); #3;
    chk("nosof_err_lit", bus.err_sync, 1'b1);
    beat(8'h51, 1, 0);
    beat(8'h52, 0, 0);
    beat(8'h53, 0, 1);
    beat(8'h61, 1, 0);
    beat(8'h62, 0, 0); #3;
    chk("restart_err_lit", bus.err_sync, 1'b1);
    beat(8'h63, 0, 1);
    beat(8'h64, 0, 0);
    beat(8'h65, 0, 0);
    beat(8'h66, 0, 1);
    idle(1); #3;
    chk("restart_data_lit", bus.frame_data, 48'h666564636261);
    chk("restart_cnt_lit",  bus.frame_cnt,  16'd6);

    // reset while a frame is held and another is filling
    beat(8'h81, 1, 0);
    beat(8'h82, 0, 0);
    @(negedge clk);
    rst = 1; bus.s_valid = 0;
    @(negedge clk);
    rst = 0; #3;
    chk("rst_mid_valid_lit", bus.frame_valid, 1'b0);
    chk("rst_mid_data_lit",  bus.frame_data,  48'h0);
    chk("rst_mid_cnt_lit",   bus.frame_cnt,   16'd0);
    chk("rst_mid_ready_lit", bus.s_ready,     1'b1);
    send_frame(8'h91);
    idle(1); #3;
    chk("post_rst_cnt_lit", bus.frame_cnt, 16'd1);
    ack_frame();

    // randomized traffic against the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst           = ($urandom % 300) == 0;
      bus.s_valid   = ($urandom % 4) != 0;
      bus.s_pix     = 8'($urandom);
      bus.s_sof     = m_fill ? (($urandom % 40) == 0) : (($urandom % 8) != 0);
      bus.s_eol     = (((m_buf.size() % W) == W - 1) ? 1'b1 : 1'b0) ^ (($urandom % 30) == 0);
      bus.frame_ack = ($urandom % 3) == 0;
    end
    @(negedge clk);
    rst = 0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
